fun_arbiter: RTL and testbench

//   Shares one cbrt(a)+sqrt(b) engine (fun-type unit: start/busy/y handshake) among N_REQ requesters.

---
 rtl/fun_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fun_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fun_arbiter.sv
// ============================================================================
//  Module      : fun_arbiter
//  Description : Round-robin sharing of one cbrt(a)+sqrt(b) engine among
//                N_REQ requesters, each with a private result register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fun_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_REQ-1:0]   start_i,
   input  logic [N_REQ*W-1:0] a_bi,
   input  logic [N_REQ*W-1:0] b_bi,
   output logic [N_REQ-1:0]   busy_o,
   output logic [N_REQ-1:0]   done_o,
   output logic [N_REQ*W-1:0] y_bo,
   output logic               eng_start_o,
   output logic [W-1:0]       eng_a_bo,
   output logic [W-1:0]       eng_b_bo,
   input  logic               eng_busy_i,
   input  logic [W-1:0]       eng_y_bi
);

   localparam int c_PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [N_REQ-1:0]           r_pending;
   logic [N_REQ-1:0][W-1:0]    r_op_a;
   logic [N_REQ-1:0][W-1:0]    r_op_b;
   logic [N_REQ-1:0][W-1:0]    r_y;
   logic [N_REQ-1:0]           r_done;
   logic [c_PTR_W-1:0]         r_ptr;
   logic [c_PTR_W-1:0]         r_grant;
   logic                       r_eng_start;
   logic [W-1:0]               r_eng_a;
   logic [W-1:0]               r_eng_b;

   logic                       w_found;
   logic [c_PTR_W-1:0]         w_win;
   logic [c_PTR_W-1:0]         w_cand;
   logic                       w_issue;
   logic                       w_finish;
   logic                       w_inflight;

   // Modular add that stays correct for non-power-of-two N_REQ.
   function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W-1:0] base,
                                                 input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ)
         s = s - N_REQ;
      return c_PTR_W'(s);
   endfunction

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         w_cand = f_wrap(r_ptr, off);
         if (!w_found && r_pending[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found && !eng_busy_i) begin
               w_issue     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Engine busy is meaningless until it has sampled our start strobe.
            if (!r_eng_start && !eng_busy_i)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_inflight = (r_state != ST_IDLE);

   generate
      for (genvar i = 0; i < N_REQ; i++) begin : g_busy
         assign busy_o[i] = r_pending[i] | (w_inflight && (r_grant == c_PTR_W'(i)));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pending   <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_y         <= '0;
         r_done      <= '0;
         r_ptr       <= c_PTR_W'(N_REQ - 1);
         r_grant     <= '0;
         r_eng_start <= 1'b0;
         r_eng_a     <= '0;
         r_eng_b     <= '0;
      end else begin
         r_done      <= '0;
         r_eng_start <= w_issue;
         for (int i = 0; i < N_REQ; i++) begin
            if (start_i[i] && !busy_o[i]) begin
               r_pending[i] <= 1'b1;
               r_op_a[i]    <= a_bi[i*W +: W];
               r_op_b[i]    <= b_bi[i*W +: W];
            end
         end
         if (w_issue) begin
            r_ptr            <= w_win;
            r_grant          <= w_win;
            r_pending[w_win] <= 1'b0;
            r_eng_a          <= r_op_a[w_win];
            r_eng_b          <= r_op_b[w_win];
         end
         if (w_finish) begin
            r_y[r_grant]    <= eng_y_bi;
            r_done[r_grant] <= 1'b1;
            r_eng_a         <= '0;
            r_eng_b         <= '0;
         end
      end
   end

   assign done_o      = r_done;
   assign y_bo        = r_y;
   assign eng_start_o = r_eng_start;
   assign eng_a_bo    = r_eng_a;
   assign eng_b_bo    = r_eng_b;

endmodule

`default_nettype wire

// File: tb/tb_fun_arbiter.sv
// ============================================================================
//  Module      : tb_fun_arbiter
//  Description : Self-checking bench for fun_arbiter with a behavioural engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fun_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   start_i = '0;
   logic [N*W-1:0] a_bi = '0;
   logic [N*W-1:0] b_bi = '0;
   logic [N-1:0]   busy_o;
   logic [N-1:0]   done_o;
   logic [N*W-1:0] y_bo;
   logic           eng_start_o;
   logic [W-1:0]   eng_a_bo;
   logic [W-1:0]   eng_b_bo;
   logic           eng_busy;
   logic [W-1:0]   eng_y;

   typedef struct {
      int idx;
      int y;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_starts = 0;
   int   done_cnt [N];
   logic prev_start = 1'b0;

   always #5 clk = ~clk;

   fun_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .start_i     (start_i),
      .a_bi        (a_bi),
      .b_bi        (b_bi),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .y_bo        (y_bo),
      .eng_start_o (eng_start_o),
      .eng_a_bo    (eng_a_bo),
      .eng_b_bo    (eng_b_bo),
      .eng_busy_i  (eng_busy),
      .eng_y_bi    (eng_y)
   );

   // Behavioural engine: busy rises after start is sampled, result at busy fall.
   function automatic int f_isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic int f_icbrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   int       eng_cnt;
   logic [W-1:0] eng_ra, eng_rb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_busy <= 1'b0;
         eng_y    <= '0;
         eng_cnt  <= 0;
         eng_ra   <= '0;
         eng_rb   <= '0;
      end else if (!eng_busy) begin
         if (eng_start_o) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 2 + int'(eng_a_bo[1:0]);
            eng_ra   <= eng_a_bo;
            eng_rb   <= eng_b_bo;
         end
      end else if (eng_cnt == 0) begin
         eng_busy <= 1'b0;
         eng_y    <= W'(f_icbrt(int'(eng_ra)) + f_isqrt(int'(eng_rb)));
      end else begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (eng_start_o) begin
            n_starts++;
            if (prev_start)
               check_eq("eng_start_width", 2, 1);
         end
         prev_start = eng_start_o;
         if (done_o != '0) begin
            check_eq("done_onehot", $countones(done_o), 1);
            for (int i = 0; i < N; i++) begin
               if (done_o[i]) begin
                  done_cnt[i]++;
                  check_eq("done_expected", int'(sb_q.size() > 0), 1);
                  if (sb_q.size() > 0) begin
                     exp_t e;
                     e = sb_q.pop_front();
                     check_eq("done_idx", i, e.idx);
                     check_eq("done_y", int'(y_bo[i*W +: W]), e.y);
                     check_eq("busy_after_done", int'(busy_o[i]), 0);
                  end
               end
            end
         end
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic set_op(input int i, input int a, input int b);
      a_bi[i*W +: W] = W'(a);
      b_bi[i*W +: W] = W'(b);
   endtask

   task automatic pulse(input logic [N-1:0] mask);
      @(posedge clk); #1;
      start_i = mask;
      @(posedge clk); #1;
      start_i = '0;
   endtask

   task automatic push_exp(input int idx, input int y);
      exp_t e;
      e.idx = idx;
      e.y   = y;
      sb_q.push_back(e);
   endtask

   task automatic wait_start(input int max_cyc);
      int ok = 0;
      for (int c = 0; c < max_cyc && ok == 0; c++) begin
         @(negedge clk);
         if (eng_start_o) ok = 1;
      end
      check_eq("wait_start_timeout", ok, 1);
   endtask

   task automatic wait_drain(input int max_cyc);
      int ok = 0;
      for (int c = 0; c < max_cyc && ok == 0; c++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && busy_o == '0) ok = 1;
      end
      check_eq("drain_timeout", ok, 1);
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int s0, d0;
      for (int i = 0; i < N; i++) done_cnt[i] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_done", int'(done_o), 0);
      check_eq("rst_y", int'(y_bo), 0);
      check_eq("rst_eng_start", int'(eng_start_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single job on requester 0
      s0 = n_starts;
      set_op(0, 27, 16);
      push_exp(0, 7);
      pulse(4'b0001);
      check_eq("t1_busy_set", int'(busy_o[0]), 1);
      wait_drain(60);
      check_eq("t1_starts", n_starts - s0, 1);
      check_eq("t1_done_cnt", done_cnt[0], 1);
      check_eq("t1_y0", int'(y_bo[7:0]), 7);
      check_eq("t1_busy", int'(busy_o), 0);

      // 2: all four on the same edge, fresh pointer
      do_reset();
      s0 = n_starts;
      for (int i = 0; i < N; i++) d0 += 0;
      set_op(0, 27, 16);  set_op(1, 64, 81);
      set_op(2, 8, 4);    set_op(3, 125, 100);
      push_exp(0, 7); push_exp(1, 13); push_exp(2, 4); push_exp(3, 15);
      pulse(4'b1111);
      wait_drain(200);
      check_eq("t2_starts", n_starts - s0, 4);
      check_eq("t2_y", int'(y_bo), 32'h0F040D07);

      // 3: after grant to 2, requesters 0 and 3 pending -> 3 first
      do_reset();
      set_op(2, 8, 4);
      push_exp(2, 4);
      pulse(4'b0100);
      wait_start(20);
      set_op(0, 27, 16);
      set_op(3, 125, 100);
      push_exp(3, 15);
      push_exp(0, 7);
      pulse(4'b1001);
      wait_drain(200);

      // 4: re-start while in flight is ignored
      do_reset();
      d0 = done_cnt[1];
      set_op(1, 64, 81);
      push_exp(1, 13);
      pulse(4'b0010);
      wait_start(20);
      set_op(1, 0, 0);
      pulse(4'b0010);
      wait_drain(100);
      repeat (10) @(negedge clk);
      check_eq("t4_y1", int'(y_bo[15:8]), 13);
      check_eq("t4_done_cnt", done_cnt[1] - d0, 1);
      check_eq("t4_busy", int'(busy_o), 0);

      // 5: back-to-back restart on requester 0
      do_reset();
      set_op(0, 27, 16);
      push_exp(0, 7);
      pulse(4'b0001);
      begin
         int ok = 0;
         for (int c = 0; c < 60 && ok == 0; c++) begin
            @(negedge clk);
            if (done_o[0]) ok = 1;
         end
         check_eq("t5_first_done", ok, 1);
      end
      check_eq("t5_y0_first", int'(y_bo[7:0]), 7);
      set_op(0, 125, 100);
      push_exp(0, 15);
      pulse(4'b0001);
      wait_drain(60);
      check_eq("t5_y0_second", int'(y_bo[7:0]), 15);

      // 6: reset in RUN clears everything immediately, job is lost
      set_op(3, 125, 100);
      pulse(4'b1000);
      wait_start(20);
      @(posedge clk); #3;
      check_eq("t6_pre_busy", int'(busy_o[3]), 1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_busy", int'(busy_o), 0);
      check_eq("t6_done", int'(done_o), 0);
      check_eq("t6_y", int'(y_bo), 0);
      check_eq("t6_eng_start", int'(eng_start_o), 0);
      check_eq("t6_eng_a", int'(eng_a_bo), 0);
      check_eq("t6_eng_b", int'(eng_b_bo), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_op(2, 8, 4);
      push_exp(2, 4);
      pulse(4'b0100);
      wait_drain(60);
      check_eq("t6_y2", int'(y_bo[23:16]), 4);
      check_eq("t6_y0_cleared", int'(y_bo[7:0]), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
